mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM-stage load/store). Each port uses a req/ready handshake. The pipeline stalls its stage while req is high and ready has not pulsed. The arbiter sequences each access through a small FSM, gives the data port priority, bounds instruction-fetch starvation and flags unanswered memory accesses.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
STARVE_MAX, 3, max consecutive data grants while IF waits; next grant forced to IF
TIMEOUT, 15, WAIT-state cycles without mem_ack_i before abort (counter width = clog2(TIMEOUT+1))
ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; held until if_ready_o
if_addr_i  in  AW  fetch address, stable while if_req_i
if_rdata_o  out  DW  fetched instruction; valid with if_ready_o, held until next IF completion
if_ready_o  out  1  one-cycle completion pulse
dm_req_i  in  1  data request; held until dm_ready_o
dm_we_i  in  1  1=store, 0=load
dm_addr_i  in  AW  data address
dm_wdata_i  in  DW  store data
dm_rdata_o  out  DW  load data; valid with dm_ready_o, held until next DM completion
dm_ready_o  out  1  one-cycle completion pulse
mem_en_o  out  1  memory access strobe, exactly one cycle per transaction
mem_we_o  out  1  memory write enable, qualified by mem_en_o
mem_addr_o  out  AW  memory address, held from ISSUE through RESP
mem_wdata_o  out  DW  memory write data, held from ISSUE through RESP
mem_rdata_i  in  DW  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion; legal in ISSUE or WAIT
busy_o  out  1  state != IDLE
err_o  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; rdata regs 0; starve_cnt=0; tmo_cnt=0; owner=IF. Assertion mid-transaction aborts it; no ready pulse.
- All outputs are registered.
- States:
  - IDLE: arbitrate. If dm_req_i and (starve_cnt<STARVE_MAX or !if_req_i), grant DM. Else if if_req_i, grant IF. Else stay in IDLE. On grant, latch owner/addr/we/wdata (IF: we=0) and go to ISSUE.
  - ISSUE: mem_en_o=1 for this cycle only. If mem_ack_i, capture data and go to RESP. Else go to WAIT with tmo_cnt=0.
  - WAIT: mem_en_o=0. If mem_ack_i, capture data and go to RESP. Else tmo_cnt++. When tmo_cnt reaches TIMEOUT, set err_o, capture ERR_DATA and go to RESP.
  - RESP: pulse the owner's ready; update that owner's rdata (stores also update dm_rdata_o with the captured value); go to IDLE.
- Minimum latency: req seen in IDLE at cycle N, ack in ISSUE at N+1, ready at N+2; 3 cycles per access. There is no back-to-back issue: RESP always returns to IDLE.
- Starvation counter:
  - Increments on a DM grant while if_req_i=1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Clears on a DM grant with if_req_i=0.
- Simultaneous requests in IDLE: DM wins unless starve_cnt==STARVE_MAX.
- A requester that drops req mid-transaction does not abort it: memory is still accessed and ready still pulses. The requester ignores the pulse.
- mem_ack_i outside ISSUE/WAIT is ignored.
- A second mem_ack_i in the same transaction is ignored.
- Stores go through the same path; mem_rdata_i on store ack is don't-care.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - owner encoding: OWN_IF=1'b0, OWN_DM=1'b1
  - ERR_DATA default
- One natural sub-module: mem_arb_sel, the combinational priority/starvation grant logic (inputs if_req, dm_req, starve_cnt; outputs grant_dm, grant_if).
- FSM, counters and output registers stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 with dm_req_i=1 -> all outputs 0 and busy_o=0. Release; DM granted next cycle: mem_en_o=1 at N+1.
2. IF-only load, ack in ISSUE: if_addr_i=0x10, mem_rdata_i=0x2001_0005 -> if_ready_o pulses at N+2 with if_rdata_o=0x2001_0005; mem_en_o high exactly 1 cycle; mem_we_o=0.
3. Store with 3-cycle memory delay: dm_we_i=1, addr 0x40, wdata 0xCAFE_0001, ack 3 cycles after ISSUE -> mem_we_o=1, mem_addr_o=0x40 held until RESP; dm_ready_o is one pulse; if_ready_o stays 0.
4. Continuous if_req_i and dm_req_i, zero-wait memory -> grant order DM,DM,DM,IF,DM,DM,DM,IF; IF never waits more than 3 DM transactions.
5. Timeout: no mem_ack_i after DM load issue -> dm_ready_o at ISSUE+TIMEOUT+2 with dm_rdata_o=0xDEAD_BEEF; err_o=1 and stays 1 over later good transactions.
6. Reset mid-WAIT: assert rst_n=0 during WAIT, then send ack after release -> no ready pulse, state IDLE, late ack ignored; next request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state, owner and error-data definitions for mem_port_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/mem_arb_sel.sv
// ============================================================================
// Module   : mem_arb_sel
// Purpose  : Data-priority grant selection with bounded instruction-fetch starvation
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_sel #(
    parameter int STARVE_MAX = 3,
    parameter int SW         = 2
) (
    input  logic          if_req,
    input  logic          dm_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_dm,
    output logic          grant_if
);

    // Data wins unless fetch has already been passed over STARVE_MAX times.
    always_comb begin
        grant_dm = dm_req && ((starve_cnt < SW'(STARVE_MAX)) || !if_req);
        grant_if = if_req && !grant_dm;
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between the fetch and data ports
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            STARVE_MAX = 3,
    parameter int            TIMEOUT    = 15,
    parameter logic [DW-1:0] ERR_DATA   = DW'(ERR_DATA_DEFAULT)
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ready_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_ready_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i,
    output logic          busy_o,
    output logic          err_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t      r_state;
    logic            r_owner;
    logic [SW-1:0]   r_starve_cnt;
    logic [TW-1:0]   r_tmo_cnt;

    logic            w_grant_dm;
    logic            w_grant_if;
    logic            w_ack_take;
    logic            w_tmo_hit;
    logic [DW-1:0]   w_resp_data;

    mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_sel (
        .if_req     (if_req_i),
        .dm_req     (dm_req_i),
        .starve_cnt (r_starve_cnt),
        .grant_dm   (w_grant_dm),
        .grant_if   (w_grant_if)
    );

    // Acks outside ISSUE/WAIT are dropped, which also covers duplicate acks.
    always_comb begin
        w_ack_take  = mem_ack_i && ((r_state == ISSUE) || (r_state == WAIT));
        w_tmo_hit   = (r_state == WAIT) && !mem_ack_i && (r_tmo_cnt == TW'(TIMEOUT));
        w_resp_data = w_tmo_hit ? ERR_DATA : mem_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
            if_rdata_o   <= '0;
            if_ready_o   <= 1'b0;
            dm_rdata_o   <= '0;
            dm_ready_o   <= 1'b0;
            mem_en_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            if_ready_o <= 1'b0;
            dm_ready_o <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grant_dm || w_grant_if) begin
                        r_state     <= ISSUE;
                        mem_en_o    <= 1'b1;
                        busy_o      <= 1'b1;
                        r_owner     <= w_grant_dm ? OWN_DM : OWN_IF;
                        mem_addr_o  <= w_grant_dm ? dm_addr_i : if_addr_i;
                        mem_we_o    <= w_grant_dm && dm_we_i;
                        mem_wdata_o <= w_grant_dm ? dm_wdata_i : '0;
                        // Only data grants taken over a waiting fetch count toward starvation.
                        if (w_grant_if || !if_req_i) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    mem_en_o  <= 1'b0;
                    r_tmo_cnt <= '0;
                    r_state   <= w_ack_take ? RESP : WAIT;
                end
                WAIT: begin
                    if (w_ack_take || w_tmo_hit) begin
                        r_state <= RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Completion: ready and read data are registered on entry to RESP.
            if (w_ack_take || w_tmo_hit) begin
                if (r_owner == OWN_DM) begin
                    dm_ready_o <= 1'b1;
                    dm_rdata_o <= w_resp_data;
                end else begin
                    if_ready_o <= 1'b1;
                    if_rdata_o <= w_resp_data;
                end
                if (w_tmo_hit) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized and directed self-checking bench for mem_port_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int          AW         = 32;
    localparam int          DW         = 32;
    localparam int          STARVE_MAX = 3;
    localparam int          TIMEOUT    = 15;
    localparam logic [31:0] C_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          C_NO_ACK   = 99;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic [DW-1:0] if_rdata_o;
    logic          if_ready_o;
    logic          dm_req_i = 1'b0;
    logic          dm_we_i = 1'b0;
    logic [AW-1:0] dm_addr_i = '0;
    logic [DW-1:0] dm_wdata_i = '0;
    logic [DW-1:0] dm_rdata_o;
    logic          dm_ready_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_ack_i = 1'b0;
    logic          busy_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    int          errors = 0;
    int          checks = 0;

    // Transaction-level reference state.
    int          m_streak = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_ready"}, if_ready_o, 0);
        check({tag, "_dm_ready"}, dm_ready_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_mem_en"}, mem_en_o, 0);
        check({tag, "_if_rdata"}, if_rdata_o, m_if_rdata);
        check({tag, "_dm_rdata"}, dm_rdata_o, m_dm_rdata);
        check({tag, "_err"}, err_o, m_err);
    endtask

    // One arbitration + access, starting from IDLE at a negedge.
    // d = ack delay in cycles after ISSUE (0 = ack in ISSUE); > TIMEOUT+1 = never.
    task automatic do_round(input int d, input logic [31:0] rd, input bit drop, output bit was_dm);
        bit          exp_dm;
        bit          tmo;
        bit          seen;
        int          exp_c;
        int          c;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_we;

        was_dm = 1'b0;
        if (!if_req_i && !dm_req_i) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check_quiet("no_req");
            return;
        end

        exp_dm = dm_req_i && !(if_req_i && (m_streak >= STARVE_MAX));
        if (exp_dm && if_req_i) m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
        else                    m_streak = 0;
        exp_addr  = exp_dm ? dm_addr_i : if_addr_i;
        exp_we    = exp_dm && dm_we_i;
        exp_wdata = dm_wdata_i;

        @(posedge clk_i);
        @(negedge clk_i);
        check("issue_en", mem_en_o, 1);
        check("issue_busy", busy_o, 1);
        check("issue_addr", mem_addr_o, exp_addr);
        check("issue_we", mem_we_o, exp_we);
        if (exp_dm) check("issue_wdata", mem_wdata_o, exp_wdata);

        if (drop) begin
            if (exp_dm) dm_req_i = 1'b0;
            else        if_req_i = 1'b0;
        end

        tmo   = (d > TIMEOUT + 1);
        exp_c = tmo ? TIMEOUT + 1 : d;
        seen  = 1'b0;
        c     = 0;
        while (!seen && c <= TIMEOUT + 3) begin
            mem_ack_i   = (c == d);
            mem_rdata_i = (c == d) ? rd : $urandom;
            @(posedge clk_i);
            @(negedge clk_i);
            check("en_single", mem_en_o, 0);
            if (if_ready_o || dm_ready_o) seen = 1'b1;
            else                          c++;
        end
        mem_ack_i = 1'b0;

        check("ready_seen", seen, 1);
        check("latency", c, exp_c);
        exp_data = tmo ? C_ERR_DATA : rd;
        if (tmo) m_err = 1'b1;
        if (exp_dm) m_dm_rdata = exp_data;
        else        m_if_rdata = exp_data;
        check("resp_if_ready", if_ready_o, !exp_dm);
        check("resp_dm_ready", dm_ready_o, exp_dm);
        check("resp_if_rdata", if_rdata_o, m_if_rdata);
        check("resp_dm_rdata", dm_rdata_o, m_dm_rdata);
        check("resp_err", err_o, m_err);
        check("resp_addr_held", mem_addr_o, exp_addr);
        check("resp_we_held", mem_we_o, exp_we);

        // Requester retires; a stray ack during RESP must be ignored.
        if (exp_dm) dm_req_i = 1'b0;
        else        if_req_i = 1'b0;
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        @(posedge clk_i);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        check_quiet("after_resp");
        was_dm = exp_dm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit wd;
        int dly;

        // Reset held with a pending data request.
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h80;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_quiet("reset");
        check("reset_addr", mem_addr_o, 0);
        rst_n = 1'b1;
        do_round(0, 32'h1234_5678, 1'b0, wd);
        check("reset_first_dm", wd, 1);

        // Fetch-only load answered in ISSUE.
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        do_round(0, 32'h2001_0005, 1'b0, wd);
        check("if_load_owner", wd, 0);
        check("if_load_data", if_rdata_o, 32'h2001_0005);

        // Store with a 3-cycle memory delay.
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h40;
        dm_wdata_i = 32'hCAFE_0001;
        do_round(3, 32'h0BAD_0BAD, 1'b0, wd);
        check("store_owner", wd, 1);

        // Saturated contention: DM,DM,DM,IF repeating.
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h200;
        for (int i = 0; i < 8; i++) begin
            do_round(0, $urandom, 1'b0, wd);
            check("starve_order", wd, ((i % 4) != 3));
            if (i < 7) begin
                if (wd) begin dm_req_i = 1'b1; dm_addr_i = dm_addr_i + 4; end
                else    begin if_req_i = 1'b1; if_addr_i = if_addr_i + 4; end
            end
        end
        while (if_req_i || dm_req_i) do_round(0, $urandom, 1'b0, wd);

        // Timeout on a data load, then error stays sticky.
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h300;
        do_round(C_NO_ACK, 32'h1111_1111, 1'b0, wd);
        check("tmo_data", dm_rdata_o, C_ERR_DATA);
        check("tmo_err", err_o, 1);
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        do_round(1, 32'h5555_AAAA, 1'b0, wd);
        check("err_sticky", err_o, 1);

        // Randomized traffic.
        for (int r = 0; r < 60; r++) begin
            if (!if_req_i && ($urandom_range(0, 2) != 0)) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom;
            end
            if (!dm_req_i && ($urandom_range(0, 2) != 0)) begin
                dm_req_i   = 1'b1;
                dm_we_i    = 1'($urandom_range(0, 1));
                dm_addr_i  = $urandom;
                dm_wdata_i = $urandom;
            end
            dly = ($urandom_range(0, 9) == 0) ? C_NO_ACK : int'($urandom_range(0, 4));
            do_round(dly, $urandom, ($urandom_range(0, 7) == 0), wd);
        end
        while (if_req_i || dm_req_i) do_round(0, $urandom, 1'b0, wd);

        // Reset in the middle of WAIT; a late ack must not complete anything.
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h400;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid_issue_en", mem_en_o, 1);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("mid_wait_busy", busy_o, 1);
        rst_n    = 1'b0;
        dm_req_i = 1'b0;
        m_err      = 1'b0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
        m_streak   = 0;
        #1;
        check_quiet("mid_reset");
        @(negedge clk_i);
        rst_n       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check_quiet("late_ack");
        end
        mem_ack_i = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h30;
        do_round(2, 32'h600D_F00D, 1'b0, wd);
        check("post_reset_data", if_rdata_o, 32'h600D_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
